// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the programmable synchronous FIFO:
//   FIFO_MODE_STD / FIFO_MODE_FWFT : values of the FWFT read-mode parameter
//   ptr_full / ptr_empty           : full/empty tests on wrap-bit pointers
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointers carry one extra wrap bit, so a full FIFO is the case where the
    // two pointers address the same slot but sit on different laps.
    // Callers zero-extend their pointers to 32 bits and pass the real width.
    function automatic logic ptr_full(input logic [31:0] wrPtr,
                                      input logic [31:0] rdPtr,
                                      input int          ptrWidth);
        logic [31:0] wrapBit;
        wrapBit = 32'd1 << (ptrWidth - 1);
        return ((wrPtr ^ rdPtr) == wrapBit);
    endfunction

    function automatic logic ptr_empty(input logic [31:0] wrPtr,
                                       input logic [31:0] rdPtr);
        return (wrPtr == rdPtr);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port RAM, no reset on the storage.
//   clock     : rising-edge clock
//   wrEn_i    : write strobe
//   wrAddr_i  : write address
//   wrData_i  : write data
//   rdAddr_i  : read address
//   rdData_o  : read data, registered (REG_READ=1) or combinational (REG_READ=0)
// -----------------------------------------------------------------------------
module fifo_ram #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int REG_READ = 0
) (
    input  logic             clock,
    input  logic             wrEn_i,
    input  logic [AW-1:0]    wrAddr_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic [AW-1:0]    rdAddr_i,
    output logic [WIDTH-1:0] rdData_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    generate
        if (REG_READ != 0) begin : g_regRead
            logic [WIDTH-1:0] rdData_q;
            always_ff @(posedge clock) begin
                rdData_q <= mem[rdAddr_i];
            end
            assign rdData_o = rdData_q;
        end else begin : g_combRead
            assign rdData_o = mem[rdAddr_i];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// occupancy count, programmable almost-full/almost-empty, sticky error flags
// and synchronous flush.
//   clock, resetn (sync, active-low), flush
//   wr_en/wr_data           : write side
//   rd_en/rd_data/rd_valid  : read side (rd_en pops the head word in FWFT mode)
//   full/empty/almost_full/almost_empty/count : status from the registered count
//   af_thresh/ae_thresh     : quasi-static thresholds
//   overflow/underflow      : sticky errors, cleared by clr_err
// -----------------------------------------------------------------------------
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int PT_WIDTH = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                flush,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_en,
    output logic [WIDTH-1:0]    rd_data,
    output logic                rd_valid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    input  logic [PT_WIDTH:0]   af_thresh,
    input  logic [PT_WIDTH:0]   ae_thresh,
    output logic [PT_WIDTH:0]   count,
    output logic                overflow,
    output logic                underflow,
    input  logic                clr_err
);

    localparam logic [PT_WIDTH:0] PtrOne = {{PT_WIDTH{1'b0}}, 1'b1};

    logic [PT_WIDTH:0] wrPtr_q, wrPtr_d;
    logic [PT_WIDTH:0] rdPtr_q, rdPtr_d;
    logic [PT_WIDTH:0] count_q, count_d;
    logic [WIDTH-1:0]  rdData_q, rdData_d;
    logic              rdValid_q, rdValid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wrAccept, rdAccept;
    logic [WIDTH-1:0]  ramData;

    assign full         = ptr_full(32'(wrPtr_q), 32'(rdPtr_q), PT_WIDTH + 1);
    assign empty        = ptr_empty(32'(wrPtr_q), 32'(rdPtr_q));
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wrAccept = wr_en & ~full;
    assign rdAccept = rd_en & ~empty;

    // The RAM read port is combinational in both modes: the standard-mode
    // output register lives here because it needs a reset and a hold enable.
    fifo_ram #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (PT_WIDTH),
        .REG_READ (0)
    ) u_ram (
        .clock    (clock),
        .wrEn_i   (wrAccept & ~flush),
        .wrAddr_i (wrPtr_q[PT_WIDTH-1:0]),
        .wrData_i (wr_data),
        .rdAddr_i (rdPtr_q[PT_WIDTH-1:0]),
        .rdData_o (ramData)
    );

    // FWFT shows the head word directly; forcing zero while empty keeps
    // rd_data at 0 out of reset and avoids exposing stale storage.
    assign rd_data  = (FWFT == FIFO_MODE_FWFT) ? (empty ? '0 : ramData) : rdData_q;
    assign rd_valid = (FWFT == FIFO_MODE_FWFT) ? ~empty : rdValid_q;

    // Next-state: flush overrides and discards same-cycle requests without
    // touching the error flags; error set is ordered after clear so set wins.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        rdData_d    = rdData_q;
        rdValid_d   = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (wr_en && full) begin
                overflow_d = 1'b1;
            end
            if (rd_en && empty) begin
                underflow_d = 1'b1;
            end
            if (wrAccept) begin
                wrPtr_d = wrPtr_q + PtrOne;
            end
            if (rdAccept) begin
                rdPtr_d   = rdPtr_q + PtrOne;
                rdData_d  = ramData;
                rdValid_d = 1'b1;
            end
            case ({wrAccept, rdAccept})
                2'b10:   count_d = count_q + PtrOne;
                2'b01:   count_d = count_q - PtrOne;
                default: count_d = count_q;
            endcase
        end
    end

    // State register with synchronous active-low reset; storage is untouched.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            rdData_q    <= '0;
            rdValid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            rdData_q    <= rdData_d;
            rdValid_q   <= rdValid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO. It succeeds the fixed 8-bit / 64K-deep FIFO and adds:
- selectable standard or first-word-fall-through (FWFT) read mode;
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- a synchronous flush.

It sits between a producer and a consumer in the same clock domain and is the team's default buffering block.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of storage words; power of two, >=4
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
- PT_WIDTH, $clog2(DEPTH), address width; derived, not overridden

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of FIFO contents
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request (pop in FWFT mode)
- rd_data  out  WIDTH  read data
- rd_valid  out  1  rd_data holds a freshly read word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= af_thresh
- almost_empty  out  1  count <= ae_thresh
- af_thresh  in  PT_WIDTH+1  almost-full threshold, quasi-static
- ae_thresh  in  PT_WIDTH+1  almost-empty threshold, quasi-static
- count  out  PT_WIDTH+1  words stored, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow and underflow

Behaviour:
Reset and pointers
- Reset is resetn, synchronous, active-low; clock is clock. While resetn=0:
  - pointers and count go to 0; empty=1, full=0;
  - rd_data=0, rd_valid=0, overflow=0, underflow=0.
- Storage is NOT cleared on reset. Never drive rd_data to Z.
- Pointers are PT_WIDTH+1 bits; the MSB is the wrap bit.
  - full when the pointers differ only in the MSB; empty when they are equal.
  - Pointers wrap modulo 2*DEPTH with no special case.

Accepting reads and writes
- Write accepted = wr_en & ~full. Read accepted = rd_en & ~empty.
- Flags are evaluated on the pre-edge state. So when full, a simultaneous wr_en+rd_en accepts only the read.
- count update: +1 on write-only, -1 on read-only, unchanged on both or neither.
- full, empty, almost_full and almost_empty are combinational from the registered count and thresholds. They are valid the cycle after the event that changes count.

Error flags
- overflow sets on wr_en & full; underflow sets on rd_en & empty. Both hold until clr_err=1 or reset.
- If set and clear land in the same cycle, set wins.

Flush
- flush=1: pointers and count go to 0 and rd_valid goes to 0 on the next edge.
- Same-cycle wr_en/rd_en are discarded and do not set the error flags.
- rd_data and the error flags are unchanged.
- Priority order: resetn > flush > wr/rd.

Standard mode (FWFT=0)
- On an accepted read, rd_data <= mem[rd_ptr] at the edge, and rd_valid=1 for that following cycle only.
- Read latency is 1 cycle. rd_data holds its value otherwise.

FWFT mode (FWFT=1)
- rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
- rd_en acts as an acknowledge that pops the head word.
- A write into an empty FIFO is visible on rd_data the cycle after the write edge.
- rd_data is don't-care while rd_valid=0.

Thresholds
- Threshold values above DEPTH are legal: almost_full then never asserts and almost_empty always asserts.
- Changing a threshold takes effect combinationally.

Decomposition:
- Package fifo_pkg holds:
  - localparam FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1;
  - a function for ptr_full/ptr_empty comparison on (PT_WIDTH+1)-bit pointers.
- One sub-module, fifo_ram: a simple dual-port RAM with no reset.
  - Synchronous write port.
  - Read port selectable registered or combinational via a parameter.
  - Control logic, count, flags and error logic stay in sync_fifo_prog.

Test Plan:
All scenarios use WIDTH=8, DEPTH=8.
1. Reset/fill/drain, FWFT=0: reset, then write 0x01..0x08.
   -> full=1 and count=8 after the 8th edge. Then read 8 words -> rd_data 0x01..0x08, each with a 1-cycle rd_valid pulse; empty=1 and count=0.
2. Overflow/underflow, FWFT=0: when full, write 0xAA.
   -> overflow=1, count stays 8, 0xAA never appears. When empty, pulse rd_en -> underflow=1 and rd_valid stays 0. Then clr_err -> both flags 0.
3. Simultaneous read and write:
   - at count=3, wr_en+rd_en -> count stays 3 and data order is preserved;
   - at full, wr_en+rd_en -> count becomes 7 and overflow=1.
4. FWFT=1: write 0x5C into an empty FIFO.
   -> rd_valid=1 and rd_data=0x5C the next cycle without rd_en. A rd_en pulse -> rd_valid=0 the following cycle.
5. Thresholds: af_thresh=6, ae_thresh=2; write 6 words one per cycle.
   -> almost_empty deasserts when count reaches 3; almost_full asserts when count reaches 6.
6. Flush and wrap:
   - write 5 words, then flush together with wr_en -> count=0, empty=1, no overflow;
   - then push/pop 20 words continuously -> pointers wrap and data order stays intact;
   - assert resetn=0 mid-stream -> all outputs at reset values on the next edge.
